// File: rtl/spi_xfer_ctrl_if.sv
// Control and status bundle between the SPI register block and the transfer
// sequencer; the register side uses the master modport, the sequencer the slave.
interface spi_xfer_ctrl_if;
   logic       spe;
   logic       mstr;
   logic       start;
   logic       cpol;
   logic       cpha;
   logic [2:0] sppr;
   logic [2:0] spr;
   logic       ss;
   logic       sclk;
   logic       send_data;
   logic       receive_data;
   logic       flags_low;
   logic       flags_high;
   logic       flag_low;
   logic       flag_high;
   logic       tip;
   logic       done;

   modport master (
      output spe, mstr, start, cpol, cpha, sppr, spr,
      input  ss, sclk, send_data, receive_data, flags_low, flags_high,
             flag_low, flag_high, tip, done
   );

   modport slave (
      input  spe, mstr, start, cpol, cpha, sppr, spr,
      output ss, sclk, send_data, receive_data, flags_low, flags_high,
             flag_low, flag_high, tip, done
   );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: runs one 16-edge byte transfer per start,
// generating sclk plus the drive/sample strobes for the shift datapath.
module spi_xfer_ctrl (
   input  logic           PCLK,
   input  logic           PRESETn,
   spi_xfer_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

   state_t      state_q, state_d;
   logic        cpol_l_q, cpol_l_d;
   logic [2:0]  sppr_l_q, sppr_l_d;
   logic [2:0]  spr_l_q, spr_l_d;
   logic [10:0] baud_cnt_q, baud_cnt_d;
   logic [4:0]  edge_cnt_q, edge_cnt_d;
   logic        sclk_q, sclk_d;

   logic [10:0] half;
   logic [10:0] half_m1;
   logic [10:0] half_m2;
   logic        in_xfer;
   logic        at_wrap;
   logic        at_drive;

   // Half period ranges 1..1024, so it always fits the 11-bit counter.
   assign half    = (11'(sppr_l_q) + 11'd1) << spr_l_q;
   assign half_m1 = half - 11'd1;
   assign half_m2 = half - 11'd2;
   assign in_xfer = (state_q == XFER);
   assign at_wrap = in_xfer && (baud_cnt_q == half_m1);
   // With H==1 there is no earlier cycle, so the drive strobe coincides with the sample strobe.
   assign at_drive = in_xfer && ((half == 11'd1) ? (baud_cnt_q == 11'd0)
                                                 : (baud_cnt_q == half_m2));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         cpol_l_q   <= 1'b0;
         sppr_l_q   <= 3'd0;
         spr_l_q    <= 3'd0;
         baud_cnt_q <= 11'd0;
         edge_cnt_q <= 5'd0;
         sclk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpol_l_q   <= cpol_l_d;
         sppr_l_q   <= sppr_l_d;
         spr_l_q    <= spr_l_d;
         baud_cnt_q <= baud_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sclk_q     <= sclk_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cpol_l_d   = cpol_l_q;
      sppr_l_d   = sppr_l_q;
      spr_l_d    = spr_l_q;
      baud_cnt_d = 11'd0;
      edge_cnt_d = 5'd0;
      sclk_d     = bus.cpol;

      case (state_q)
         IDLE: begin
            if (bus.start && bus.spe && bus.mstr) state_d = LOAD;
         end
         LOAD: begin
            cpol_l_d = bus.cpol;
            sppr_l_d = bus.sppr;
            spr_l_d  = bus.spr;
            state_d  = XFER;
         end
         XFER: begin
            sclk_d     = sclk_q;
            baud_cnt_d = baud_cnt_q + 11'd1;
            edge_cnt_d = edge_cnt_q;
            if (at_wrap) begin
               baud_cnt_d = 11'd0;
               sclk_d     = ~sclk_q;
               edge_cnt_d = edge_cnt_q + 5'd1;
               if (edge_cnt_q == 5'd15) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Losing the enable abandons the transfer silently, without a completion pulse.
      if (!bus.spe) begin
         state_d    = IDLE;
         baud_cnt_d = 11'd0;
         edge_cnt_d = 5'd0;
         sclk_d     = bus.cpol;
      end
   end

   assign bus.ss           = ~in_xfer;
   assign bus.tip          = in_xfer;
   assign bus.sclk         = sclk_q;
   assign bus.send_data    = (state_q == LOAD);
   assign bus.done         = (state_q == DONE);
   assign bus.receive_data = (state_q == DONE);
   assign bus.flag_high    = at_wrap & sclk_q;
   assign bus.flag_low     = at_wrap & ~sclk_q;
   assign bus.flags_high   = at_drive & sclk_q;
   assign bus.flags_low    = at_drive & ~sclk_q;

endmodule
